// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Elastic 2-entry (main + skid) pipeline register for {pc, instr}
//                with valid/ready handshake, registered ready, flush and NOP
//                bubble insertion. Optional counters enabled by PIPE_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int          PC_W      = 12,
    parameter int          INSTR_W   = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    localparam logic [INSTR_W-1:0] C_NOP = INSTR_W'(NOP_INSTR);

    logic               r_main_valid;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_main_instr;
    logic               r_skid_valid;
    logic [PC_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic               r_in_ready;

    logic w_accept;
    logic w_pop;
    logic w_main_valid_nxt;
    logic w_skid_valid_nxt;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_main_valid & out_ready;

    // Skid is only ever filled while main is held, so in_ready tracks skid alone.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (r_skid_valid) begin
            if (w_pop) begin
                w_load_main_skid = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_pop) begin
                w_load_main_in   = 1'b1;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_load_skid      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_pop) begin
            w_main_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_main_pc    <= '0;
            r_main_instr <= C_NOP;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
            if (w_load_main_in) begin
                r_main_pc    <= in_pc;
                r_main_instr <= in_instr;
            end else if (w_load_main_skid) begin
                r_main_pc    <= r_skid_pc;
                r_main_instr <= r_skid_instr;
            end
        end
    end

    // Skid payload is qualified by r_skid_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_pc    = r_main_pc;
    assign out_instr = r_main_valid ? r_main_instr : C_NOP;
    assign occupancy = r_skid_valid ? 2'd2 : (r_main_valid ? 2'd1 : 2'd0);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating counters; flush deliberately leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (in_valid && !r_in_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!r_main_valid && out_ready && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg; queue-based reference
//                model plus directed literal checks and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          PC_W    = 12;
    localparam int          INSTR_W = 32;
    localparam int          CNT_W   = 4;
    localparam logic [31:0] NOP     = 32'h00000013;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [1:0]         occupancy;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .NOP_INSTR(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .occupancy(occupancy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered FIFO of at most two entries.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    ent_t            mq[$];
    bit              m_ready  = 1'b0;
    logic [PC_W-1:0] m_lastpc = '0;
    int              m_stall  = 0;
    int              m_bubble = 0;
    bit              chk_en   = 1'b0;

    always @(posedge clk) begin
        bit   acc;
        bit   pop;
        bit   ov;
        ent_t e;
        ov  = (mq.size() > 0);
        acc = in_valid && m_ready;
        pop = ov && out_ready;
        if (rst) begin
            mq.delete();
            m_ready  = 1'b0;
            m_lastpc = '0;
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (in_valid && !m_ready && m_stall < CMAX) m_stall++;
            if (!ov && out_ready && m_bubble < CMAX) m_bubble++;
            if (!flush) begin
                if (pop) void'(mq.pop_front());
                if (acc) begin
                    e.pc    = in_pc;
                    e.instr = in_instr;
                    mq.push_back(e);
                end
            end else begin
                mq.delete();
            end
            m_ready = (mq.size() < 2);
            if (mq.size() > 0) m_lastpc = mq[0].pc;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(m_ready));
            chk("out_pc", 64'(out_pc), 64'(m_lastpc));
            chk("out_instr", 64'(out_instr), (mq.size() > 0) ? 64'(mq[0].instr) : 64'(NOP));
`ifdef PIPE_PERF_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        tick();
    endtask

    initial begin
        bit pend;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;

        // Reset
        repeat (3) begin
            tick();
            chk("rst_in_ready", 64'(in_ready), 64'd0);
        end
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'h13);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(PC_W'(4 * i), INSTR_W'(32'hA + i));
            chk("stream_pc", 64'(out_pc), 64'(4 * i));
            chk("stream_instr", 64'(out_instr), 64'(32'hA + i));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();

        // Back-pressure
        out_ready = 1'b0;
        push(12'h010, 32'h100);
        push(12'h014, 32'h104);
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_ready", 64'(in_ready), 64'd0);
        push(12'h018, 32'h108);
        chk("bp_held_pc", 64'(out_pc), 64'h010);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_pc", 64'(out_pc), 64'h014);
        chk("bp_pop1_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_pop2_pc", 64'(out_pc), 64'h018);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush while full, with an entry on the input
        out_ready = 1'b0;
        push(12'h01c, 32'h11c);
        push(12'h01e, 32'h11e);
        in_pc = 12'h020; in_instr = 32'h120; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_instr", 64'(out_instr), 64'h13);
        chk("fl_ready", 64'(in_ready), 64'd1);
        chk("fl_pc_hold", 64'(out_pc), 64'h01c);
        out_ready = 1'b1;
        tick();
        chk("fl_no_020", 64'(out_valid), 64'd0);

        // Mid-operation reset together with flush
        out_ready = 1'b0;
        push(12'h030, 32'h130);
        push(12'h034, 32'h134);
        in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
        tick();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_occ", 64'(occupancy), 64'd0);
        chk("mr_pc", 64'(out_pc), 64'd0);
        chk("mr_instr", 64'(out_instr), 64'h13);
        chk("mr_ready", 64'(in_ready), 64'd0);
        rst = 1'b0; flush = 1'b0;

        // Counter scenario (datapath is still checked in the default build)
        for (int i = 0; i < 10; i++) push(PC_W'(12'h040 + i), INSTR_W'(32'h140 + i));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt_8", 64'(stall_cnt), 64'd8);
`endif
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
`ifdef PIPE_PERF_CNT_EN
        chk("bubble_cnt_3", 64'(bubble_cnt), 64'd3);
`endif
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) push(PC_W'(12'h050 + i), INSTR_W'(32'h150 + i));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt_sat", 64'(stall_cnt), 64'hF);
`endif

        // Randomized phase; upstream holds a payload it could not hand over
        for (int i = 0; i < 600; i++) begin
            pend      = in_valid && !in_ready && !flush && !rst;
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = PC_W'($urandom);
                in_instr = $urandom;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic successor to the fixed IF/ID latch.
- A 2-entry pipeline stage register (main + skid) carrying {pc, instr} between any two pipeline stages.
- Uses a valid/ready handshake, a synchronous flush, and bubble (NOP) insertion.
- Supports full throughput with a registered ready, so a back-pressure path never becomes combinational across stages.

Parameters:
- PC_W, 12, width of the program-counter field.
- INSTR_W, 32, width of the instruction field.
- NOP_INSTR, 32'h00000013, value driven on out_instr when no valid entry is presented (RV32I addi x0,x0,0); truncated or zero-extended to INSTR_W.
- CNT_W, 16, width of the performance counters (used only when PIPE_PERF_CNT_EN is defined).

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  stage can accept an entry; registered.
- in_pc  input  PC_W  upstream PC.
- in_instr  input  INSTR_W  upstream instruction.
- flush  input  1  discard all held entries and any entry presented this cycle.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts the main entry.
- out_pc  output  PC_W  PC of the main entry.
- out_instr  output  INSTR_W  instruction of the main entry, or NOP_INSTR when out_valid=0.
- occupancy  output  2  number of held entries (0..2).

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-high (rst). All state updates on posedge clk only.
- Reset:
  - main_valid=0, skid_valid=0, out_valid=0, occupancy=0.
  - out_pc=0, out_instr=NOP_INSTR.
  - in_ready=0 while rst=1; in_ready=1 on the first cycle after rst deasserts.
- Handshake events:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Payload is captured only on accept; in_pc/in_instr are ignored otherwise.
- Latency and throughput:
  - Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
  - Sustained throughput is 1 entry/cycle when out_ready=1.
- Next-state rules (flush=0):
  - Empty + accept: entry goes to main.
  - Main only + accept + pop: new entry replaces main.
  - Main only + accept + !pop: new entry goes to skid (occupancy 2).
  - Main only + pop + !accept: main is cleared.
  - Full + pop: skid moves to main and skid is cleared. No accept is possible since in_ready=0.
- in_ready is registered: in_ready_next = !(next skid_valid). It is deasserted only when occupancy reaches 2.
- Entry order is preserved. No entry is duplicated or dropped except by flush.
- Flush:
  - flush=1 at an edge: main_valid=0, skid_valid=0, occupancy=0.
  - out_instr returns to NOP_INSTR; in_ready=1 next cycle.
  - An entry presented with accept in the same cycle is discarded. Flush dominates pop and accept.
- out_pc holds its last value when out_valid=0. It is not cleared except by reset.
- rst asserted mid-operation: all held entries are lost; same values as reset; rst dominates flush.
- in_ready=0 with in_valid=1 is legal. Upstream is required to hold its payload; the stage does not capture it.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[CNT_W-1:0], counting cycles with in_valid & !in_ready.
  - Adds bubble_cnt[CNT_W-1:0], counting cycles with !out_valid & out_ready.
  - Both counters reset to 0 on rst, saturate at all-ones (no wrap), and are not cleared by flush.
- Not defined: neither port nor counter logic exists. Datapath behaviour is identical either way.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release -> out_valid=0, out_instr=32'h00000013, out_pc=0, occupancy=0; in_ready=0 during rst and 1 on the cycle after.
- Streaming: out_ready=1; push pc 0x000,0x004,0x008 with instr 0xA,0xB,0xC on consecutive cycles -> the same triples appear one cycle later, back-to-back, with in_ready stuck at 1.
- Back-pressure: out_ready=0; push pc 0x010 then 0x014 -> occupancy=2, in_ready=0, and a third entry 0x018 held at the input is not taken. Raise out_ready -> output order 0x010, 0x014, 0x018, and in_ready returns to 1 one cycle after the first pop.
- Flush: with occupancy=2, assert flush while in_valid=1 carries pc 0x020 -> next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR; 0x020 is never output.
- Mid-operation reset: with occupancy=2, assert rst together with flush -> outputs equal reset values and out_pc=0.
- PIPE_PERF_CNT_EN: hold in_valid=1 and out_ready=0 for 10 cycles after reset -> stall_cnt=8. Then drive out_ready=1 and in_valid=0 for 5 cycles -> bubble_cnt increments exactly once per cycle with out_valid=0. With CNT_W=4, run 20 stalled cycles -> stall_cnt=4'hF.
